// File: rtl/dma_pkg.sv
// Shared definitions for the DMA command interface: register map,
// STATUS bit positions, DMA progress bit positions and FSM states.
package dma_pkg;

    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_LENGTH  = 5'h04;
    localparam logic [4:0] REG_SRC_LSB = 5'h08;
    localparam logic [4:0] REG_SRC_MSB = 5'h0C;
    localparam logic [4:0] REG_DST_LSB = 5'h10;
    localparam logic [4:0] REG_DST_MSB = 5'h14;
    localparam logic [4:0] REG_STATUS  = 5'h18;
    localparam logic [4:0] REG_ACK     = 5'h1C;

    localparam int ST_LOAD   = 1;
    localparam int ST_STORE  = 2;
    localparam int ST_CMPL   = 3;
    localparam int ST_ACTIVE = 4;
    localparam int ST_REJECT = 5;
    localparam int ST_TMO    = 6;

    localparam int VALID_LOAD  = 1;
    localparam int VALID_STORE = 2;
    localparam int VALID_DONE  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_COMPLETE,
        S_ACK
    } state_t;

endpackage

// File: rtl/dma_cmd_if.sv
// Register-mapped command front end for a DMA engine.
// Optional busy watchdog enabled by defining DMA_CMD_TIMEOUT_EN.
module dma_cmd_if
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [4:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [DATA_WIDTH-1:0] start_o,
    output logic [DATA_WIDTH-1:0] length_o,
    output logic [DATA_WIDTH-1:0] source_addr_lsb_o,
    output logic [DATA_WIDTH-1:0] source_addr_msb_o,
    output logic [DATA_WIDTH-1:0] dest_addr_lsb_o,
    output logic [DATA_WIDTH-1:0] dest_addr_msb_o,
    output logic [DATA_WIDTH-1:0] done_o,
    input  logic [DATA_WIDTH-1:0] valid_i,
    output logic                  irq_o
);

    state_t state_q, state_d;

    logic wr, rd;
    logic ctrl_go, ack_go, cfg_wr;
    logic dma_done, tmo_hit;
    logic enter_busy, to_complete, reject;
    logic [1:0] st_acc;
    logic st_cmpl, st_rej, st_tmo;
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic unused_valid;

    assign gnt_o    = req_i;
    assign wr       = req_i & we_i;
    assign rd       = req_i & ~we_i;
    assign ctrl_go  = wr && (addr_i == REG_CTRL) && wdata_i[0];
    assign ack_go   = wr && (addr_i == REG_ACK) && wdata_i[0];
    assign cfg_wr   = wr && (addr_i inside {REG_LENGTH, REG_SRC_LSB,
                      REG_SRC_MSB, REG_DST_LSB, REG_DST_MSB});
    assign dma_done = valid_i[VALID_DONE];
    assign unused_valid = ^{valid_i[DATA_WIDTH-1:4], valid_i[0]};

`ifdef DMA_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = (state_q == S_BUSY)
                  && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Held at zero outside BUSY, so every BUSY entry starts a fresh count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state_q != S_BUSY) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (ctrl_go) state_d = S_BUSY;
            S_BUSY:     if (dma_done || tmo_hit) state_d = S_COMPLETE;
            S_COMPLETE: if (ack_go) state_d = S_ACK;
            S_ACK:      if (!dma_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_o    = '0;
        done_o     = '0;
        start_o[0] = (state_q == S_BUSY);
        done_o[0]  = (state_q == S_ACK);
        irq_o      = (state_q == S_COMPLETE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            length_o          <= '0;
            source_addr_lsb_o <= '0;
            source_addr_msb_o <= '0;
            dest_addr_lsb_o   <= '0;
            dest_addr_msb_o   <= '0;
        end else if (wr && state_q == S_IDLE) begin
            case (addr_i)
                REG_LENGTH:  length_o          <= wdata_i;
                REG_SRC_LSB: source_addr_lsb_o <= wdata_i;
                REG_SRC_MSB: source_addr_msb_o <= wdata_i;
                REG_DST_LSB: dest_addr_lsb_o   <= wdata_i;
                REG_DST_MSB: dest_addr_msb_o   <= wdata_i;
                default: ;
            endcase
        end
    end

    assign enter_busy  = (state_q == S_IDLE) && ctrl_go;
    assign to_complete = (state_q == S_BUSY) && (dma_done || tmo_hit);
    assign reject      = (cfg_wr || ctrl_go) && (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_acc  <= '0;
            st_cmpl <= 1'b0;
            st_tmo  <= 1'b0;
            st_rej  <= 1'b0;
        end else begin
            if (enter_busy) begin
                st_acc  <= '0;
                st_cmpl <= 1'b0;
                st_tmo  <= 1'b0;
            end else begin
                if (state_q == S_BUSY)
                    st_acc <= st_acc | valid_i[VALID_STORE:VALID_LOAD];
                if (to_complete) st_cmpl <= 1'b1;
                if (tmo_hit)     st_tmo  <= 1'b1;
            end
            if (reject) st_rej <= 1'b1;
        end
    end

    always_comb begin
        status            = '0;
        status[ST_LOAD]   = st_acc[0];
        status[ST_STORE]  = st_acc[1];
        status[ST_CMPL]   = st_cmpl;
        status[ST_ACTIVE] = (state_q != S_IDLE);
        status[ST_REJECT] = st_rej;
        status[ST_TMO]    = st_tmo;
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            REG_LENGTH:  rd_mux = length_o;
            REG_SRC_LSB: rd_mux = source_addr_lsb_o;
            REG_SRC_MSB: rd_mux = source_addr_msb_o;
            REG_DST_LSB: rd_mux = dest_addr_lsb_o;
            REG_DST_MSB: rd_mux = dest_addr_msb_o;
            REG_STATUS:  rd_mux = status;
            default:     rd_mux = '0;
        endcase
    end

    // Data is only non-zero in the response cycle of a read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_dma_cmd_if.sv
// Directed self-checking bench for dma_cmd_if.
// Define DMA_CMD_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_dma_cmd_if;

    logic        clk;
    logic        rst_ni;
    logic        req_i;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [31:0] start_o;
    logic [31:0] length_o;
    logic [31:0] source_addr_lsb_o;
    logic [31:0] source_addr_msb_o;
    logic [31:0] dest_addr_lsb_o;
    logic [31:0] dest_addr_msb_o;
    logic [31:0] done_o;
    logic [31:0] valid_i;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    dma_cmd_if #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .req_i             (req_i),
        .we_i              (we_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .gnt_o             (gnt_o),
        .rvalid_o          (rvalid_o),
        .rdata_o           (rdata_o),
        .start_o           (start_o),
        .length_o          (length_o),
        .source_addr_lsb_o (source_addr_lsb_o),
        .source_addr_msb_o (source_addr_msb_o),
        .dest_addr_lsb_o   (dest_addr_lsb_o),
        .dest_addr_msb_o   (dest_addr_msb_o),
        .done_o            (done_o),
        .valid_i           (valid_i),
        .irq_o             (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp,
                       input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick();
        req_i = 1'b0;
        we_i  = 1'b0;
        chk(rvalid_o, 1, "wr_rvalid");
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] e,
                            input string tag);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        #1;
        chk(gnt_o, 1, "gnt");
        tick();
        req_i = 1'b0;
        chk(rvalid_o, 1, {tag, "_rvalid"});
        chk(rdata_o, e, tag);
        tick();
        chk(rvalid_o, 0, {tag, "_rvalid_low"});
        chk(rdata_o, 0, {tag, "_rdata_idle"});
    endtask

    initial begin
        rst_ni  = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        valid_i = '0;
        #1;
        chk(start_o, 0, "rst_start");
        chk(done_o, 0, "rst_done");
        chk(irq_o, 0, "rst_irq");
        chk(rvalid_o, 0, "rst_rvalid");
        chk(rdata_o, 0, "rst_rdata");
        chk(length_o, 0, "rst_length");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        bus_read(5'h14, 32'h0, "rd_dst_msb_rst");
        bus_read(5'h1F, 32'h0, "rd_unmapped");

        bus_write(5'h04, 32'd3);
        bus_write(5'h08, 32'h8000_0000);
        bus_write(5'h0C, 32'h0);
        bus_write(5'h10, 32'h8000_1000);
        bus_write(5'h14, 32'h0);
        chk(length_o, 3, "cfg_length");
        chk(source_addr_lsb_o, 32'h8000_0000, "cfg_src_lsb");
        chk(source_addr_msb_o, 0, "cfg_src_msb");
        chk(dest_addr_lsb_o, 32'h8000_1000, "cfg_dst_lsb");
        chk(dest_addr_msb_o, 0, "cfg_dst_msb");

        bus_write(5'h00, 32'h1);
        chk(start_o, 1, "t1_start");
        chk(irq_o, 0, "t1_irq_busy");
        valid_i = 32'h2;
        tick();
        valid_i = 32'h6;
        tick();
        chk(irq_o, 0, "t1_irq_before_done");
        valid_i = 32'hE;
        tick();
        chk(irq_o, 1, "t1_irq");
        chk(start_o, 0, "t1_start_complete");
        bus_read(5'h18, 32'h1E, "t1_status");
        chk(irq_o, 1, "t1_irq_held");

        bus_write(5'h1C, 32'h1);
        chk(done_o, 1, "t1_done");
        chk(irq_o, 0, "t1_irq_ack");
        tick();
        chk(done_o, 1, "t1_done_hold");
        valid_i = 32'h0;
        tick();
        chk(done_o, 0, "t1_done_idle");
        chk(start_o, 0, "t1_start_idle");
        bus_read(5'h18, 32'h0E, "t1_status_idle");

        bus_write(5'h00, 32'h1);
        chk(start_o, 1, "t2_start");
        bus_read(5'h18, 32'h10, "t2_status_busy");
        bus_write(5'h04, 32'd7);
        chk(length_o, 3, "t2_length_kept");
        bus_read(5'h18, 32'h30, "t2_status_rej");
        bus_read(5'h04, 32'd3, "t2_rd_length");
        chk(source_addr_lsb_o, 32'h8000_0000, "t2_src_stable");

        valid_i = 32'h8;
        bus_write(5'h00, 32'h1);
        chk(irq_o, 1, "t2_irq_race");
        chk(start_o, 0, "t2_start_race");
        bus_read(5'h18, 32'h38, "t2_status_race");
        bus_write(5'h1C, 32'h1);
        chk(done_o, 1, "t2_done");
        valid_i = 32'h0;
        tick();
        chk(done_o, 0, "t2_done_idle");

        bus_write(5'h00, 32'h1);
        chk(start_o, 1, "t3_start");
`ifdef DMA_CMD_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk(irq_o, 0, "tmo_irq_early");
        tick();
        chk(irq_o, 1, "tmo_irq");
        bus_read(5'h18, 32'h78, "tmo_status");
        bus_write(5'h1C, 32'h1);
        tick();
        chk(done_o, 0, "tmo_back_idle");
        bus_write(5'h00, 32'h1);
        chk(start_o, 1, "t4_start");
`else
        for (int i = 0; i < 10000; i++) tick();
        chk(start_o, 1, "no_tmo_start");
        chk(irq_o, 0, "no_tmo_irq");
        bus_read(5'h18, 32'h30, "no_tmo_status");
`endif

        rst_ni = 1'b0;
        #1;
        chk(start_o, 0, "mid_rst_start");
        chk(done_o, 0, "mid_rst_done");
        chk(irq_o, 0, "mid_rst_irq");
        chk(length_o, 0, "mid_rst_length");
        chk(source_addr_lsb_o, 0, "mid_rst_src");
        chk(dest_addr_lsb_o, 0, "mid_rst_dst");
        chk(rvalid_o, 0, "mid_rst_rvalid");
        chk(rdata_o, 0, "mid_rst_rdata");
        #3;
        rst_ni = 1'b1;
        tick();
        chk(start_o, 0, "post_rst_start");
        chk(done_o, 0, "post_rst_done");
        bus_read(5'h18, 32'h0, "post_rst_status");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
